// File: rtl/aes_v1_mix_if.sv
// Request/response bundle shared by the aes_v1 units.
//   valid : request, held with dec/rs1 stable until ready
//   dec   : 0 = MixColumns, 1 = InvMixColumns
//   rs1   : input column, byte 0 in rs1[7:0]
//   ready : one-cycle completion pulse
//   rd    : result column, zero whenever ready is low
interface aes_v1_mix_if;
  logic        valid;
  logic        dec;
  logic [31:0] rs1;
  logic        ready;
  logic [31:0] rd;

  modport master (output valid, dec, rs1, input  ready, rd);
  modport slave  (input  valid, dec, rs1, output ready, rd);
endinterface

// File: rtl/aes_v1_mix.sv
// AES MixColumns / InvMixColumns on one 32-bit column.
// Byte-serial by default (one GF(2^8) multiply-accumulate per cycle);
// ONE_CYCLE = 1 replicates the datapath and finishes in a single BUSY cycle.
// Ports:
//   g_clk    : clock
//   g_resetn : synchronous active-low reset
//   bus      : slave side of aes_v1_mix_if (valid/dec/rs1 in, ready/rd out)
module aes_v1_mix #(
  parameter bit ONE_CYCLE = 1'b0
) (
  input  logic         g_clk,
  input  logic         g_resetn,
  aes_v1_mix_if.slave  bus
);

  localparam int unsigned ColW  = 32;
  localparam int unsigned ByteW = 8;
  localparam int unsigned IdxW  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Multiply by x modulo 0x11B.
  function automatic logic [ByteW-1:0] xtime(input logic [ByteW-1:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Pick byte i of a column.
  function automatic logic [ByteW-1:0] col_byte(input logic [ColW-1:0] w,
                                                 input logic [IdxW-1:0] i);
    return w[{i, 3'b000} +: ByteW];
  endfunction

  // One output byte: coefficient row applied to a_i, a_i+1, a_i+2, a_i+3.
  function automatic logic [ByteW-1:0] mix_byte(input logic            d,
                                                 input logic [ColW-1:0] w,
                                                 input logic [IdxW-1:0] i);
    logic [ByteW-1:0] acc;
    logic [ByteW-1:0] b;
    logic [ByteW-1:0] p2;
    logic [ByteW-1:0] p4;
    logic [ByteW-1:0] p8;
    acc = '0;
    for (int k = 0; k < 4; k++) begin
      b  = col_byte(w, IdxW'(i + IdxW'(k)));
      p2 = xtime(b);
      p4 = xtime(p2);
      p8 = xtime(p4);
      if (!d) begin
        case (k)
          0:       acc = acc ^ p2;             // 02
          1:       acc = acc ^ p2 ^ b;         // 03
          default: acc = acc ^ b;              // 01
        endcase
      end else begin
        case (k)
          0:       acc = acc ^ p8 ^ p4 ^ p2;   // 0E
          1:       acc = acc ^ p8 ^ p2 ^ b;    // 0B
          2:       acc = acc ^ p8 ^ p4 ^ b;    // 0D
          default: acc = acc ^ p8 ^ b;         // 09
        endcase
      end
    end
    return acc;
  endfunction

  state_t            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [ColW-1:0]   result_q, result_d;
  logic              ready_q, ready_d;
  logic [ColW-1:0]   rd_q, rd_d;

  // Result column after this BUSY cycle, and whether it is the final one.
  logic [ColW-1:0]   busy_word_c;
  logic              busy_last_c;

  generate
    if (ONE_CYCLE) begin : g_par
      // Four datapaths, whole column in one cycle.
      always_comb begin
        busy_word_c = '0;
        for (int i = 0; i < 4; i++) begin
          busy_word_c[i*ByteW +: ByteW] = mix_byte(bus.dec, bus.rs1, IdxW'(i));
        end
        busy_last_c = 1'b1;
      end
    end else begin : g_ser
      // One datapath, byte idx merged into the running result.
      always_comb begin
        busy_word_c = result_q;
        busy_word_c[{idx_q, 3'b000} +: ByteW] = mix_byte(bus.dec, bus.rs1, idx_q);
        busy_last_c = (idx_q == IdxW'(3));
      end
    end
  endgenerate

  // State and output registers.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      rd_q     <= rd_d;
    end
  end

  // Next state; ready/rd are loaded on entry to DONE so they are high only there.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    result_d = result_q;
    ready_d  = 1'b0;
    rd_d     = '0;
    case (state_q)
      IDLE: begin
        if (bus.valid) begin
          state_d = BUSY;
          idx_d   = '0;
        end
      end
      BUSY: begin
        if (!bus.valid) begin
          // Requester withdrew: drop the operation, keep result untouched.
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          result_d = busy_word_c;
          idx_d    = idx_q + IdxW'(1);
          if (busy_last_c) begin
            state_d = DONE;
            ready_d = 1'b1;
            rd_d    = busy_word_c;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign bus.ready = ready_q;
  assign bus.rd    = rd_q;

endmodule

// File: tb/tb_aes_v1_mix.sv
// Directed bench for aes_v1_mix: byte-serial instance (i0) and
// single-cycle instance (i1), known-answer columns, latency,
// back-to-back, abort and mid-operation reset.
module tb_aes_v1_mix;

  logic g_clk;
  logic g_resetn;
  int   total;
  int   bad;

  aes_v1_mix_if i0 ();
  aes_v1_mix_if i1 ();

  aes_v1_mix #(.ONE_CYCLE(1'b0)) u_dut0 (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .bus      (i0)
  );

  aes_v1_mix #(.ONE_CYCLE(1'b1)) u_dut1 (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .bus      (i1)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic d, input logic [31:0] a);
    if (sel) begin
      i1.valid = v; i1.dec = d; i1.rs1 = a;
    end else begin
      i0.valid = v; i0.dec = d; i0.rs1 = a;
    end
  endtask

  // Called at a negedge with valid already high; counts cycles to ready.
  task automatic wait_ready(input bit sel, input int lat, input logic [31:0] exp,
                            input bit drop, input string tag);
    int          c;
    int          leaks;
    bit          seen;
    logic        r;
    logic [31:0] v;
    c = 0; leaks = 0; seen = 1'b0; v = '0;
    while (!seen && c < 40) begin
      @(negedge g_clk);
      c++;
      r = sel ? i1.ready : i0.ready;
      v = sel ? i1.rd : i0.rd;
      if (r === 1'b1) begin
        seen = 1'b1;
        if (drop) begin
          if (sel) i1.valid = 1'b0; else i0.valid = 1'b0;
        end
      end else if (v !== 32'd0) begin
        leaks++;
      end
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    check({tag, "_lat"},  32'(c),    32'(lat));
    check({tag, "_rd"},   v,         exp);
    check({tag, "_leak"}, 32'(leaks), 32'd0);
  endtask

  // Cycle after the pulse: ready must be gone and rd cleared.
  task automatic pulse_end(input bit sel, input string tag);
    @(negedge g_clk);
    check({tag, "_rdy_end"}, 32'(sel ? i1.ready : i0.ready), 32'd0);
    check({tag, "_rd_end"},  sel ? i1.rd : i0.rd,            32'd0);
  endtask

  task automatic req(input bit sel, input logic d, input logic [31:0] a,
                     input logic [31:0] exp, input int lat, input string tag);
    drive(sel, 1'b1, d, a);
    wait_ready(sel, lat, exp, 1'b1, tag);
    pulse_end(sel, tag);
  endtask

  initial begin
    int rdy_cnt;
    total = 0;
    bad   = 0;
    g_resetn = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0);
    repeat (3) @(negedge g_clk);
    check("rst_ready0", 32'(i0.ready), 32'd0);
    check("rst_rd0",    i0.rd,         32'd0);
    check("rst_ready1", 32'(i1.ready), 32'd0);
    check("rst_rd1",    i1.rd,         32'd0);
    g_resetn = 1'b1;
    @(negedge g_clk);

    // Known-answer columns and fixed points, byte-serial.
    req(1'b0, 1'b0, 32'h455313DB, 32'hBCA14D8E, 5, "enc_fips");
    req(1'b0, 1'b0, 32'h5C220AF2, 32'h9D58DC9F, 5, "enc_col2");
    req(1'b0, 1'b0, 32'h01010101, 32'h01010101, 5, "fix01_enc");
    req(1'b0, 1'b1, 32'h01010101, 32'h01010101, 5, "fix01_dec");
    req(1'b0, 1'b0, 32'hC6C6C6C6, 32'hC6C6C6C6, 5, "fixc6_enc");
    req(1'b0, 1'b1, 32'hC6C6C6C6, 32'hC6C6C6C6, 5, "fixc6_dec");

    // Inverse round trip with valid held: second pulse 6 cycles later.
    drive(1'b0, 1'b1, 1'b1, 32'hBCA14D8E);
    wait_ready(1'b0, 5, 32'h455313DB, 1'b0, "dec_rt1");
    i0.rs1 = 32'h9D58DC9F;
    wait_ready(1'b0, 6, 32'h5C220AF2, 1'b1, "dec_rt2");
    pulse_end(1'b0, "dec_rt2");

    // Abort: valid for two cycles, then withdrawn.
    drive(1'b0, 1'b1, 1'b0, 32'h455313DB);
    repeat (2) @(negedge g_clk);
    i0.valid = 1'b0;
    rdy_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge g_clk);
      if (i0.ready === 1'b1) rdy_cnt++;
    end
    check("abort_no_ready", 32'(rdy_cnt), 32'd0);
    req(1'b0, 1'b0, 32'h455313DB, 32'hBCA14D8E, 5, "after_abort");

    // Reset in the third BUSY cycle, request held throughout.
    drive(1'b0, 1'b1, 1'b0, 32'h455313DB);
    repeat (3) @(negedge g_clk);
    g_resetn = 1'b0;
    @(negedge g_clk);
    check("midrst_ready", 32'(i0.ready), 32'd0);
    check("midrst_rd",    i0.rd,         32'd0);
    g_resetn = 1'b1;
    wait_ready(1'b0, 5, 32'hBCA14D8E, 1'b1, "after_rst");
    pulse_end(1'b0, "after_rst");

    // Single-cycle build: same answers, shorter latency.
    req(1'b1, 1'b0, 32'h455313DB, 32'hBCA14D8E, 2, "oc_enc_fips");
    drive(1'b1, 1'b1, 1'b1, 32'hBCA14D8E);
    wait_ready(1'b1, 2, 32'h455313DB, 1'b0, "oc_dec_rt1");
    i1.rs1 = 32'h9D58DC9F;
    wait_ready(1'b1, 3, 32'h5C220AF2, 1'b1, "oc_dec_rt2");
    pulse_end(1'b1, "oc_dec_rt2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
